// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator job dispatcher: default widths and FSM states.
package accum_pkg;

    localparam int DATA_W_DEF   = 3;
    localparam int DEPTH_DEF    = 4;
    localparam int MAX_WAIT_DEF = 15;

    // Dispatcher control states; exported on the debug port for observation.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/accum_job_fifo.sv
// Synchronous job FIFO: a push is refused when full (even with a same-cycle pop),
// a pop is ignored when empty, pointers wrap modulo DEPTH.
module accum_job_fifo #(
    parameter  int DATA_W = 3,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/accum_dispatch.sv
// Job dispatcher: queues load values, launches them one at a time into the
// countdown unit, waits for its data to reach zero (or a watchdog timeout)
// and returns the captured timer on the result port.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends only on registered FIFO occupancy; res_valid stays high
// with res_timer/res_load/res_err held stable until res_ready is seen.
module accum_dispatch
    import accum_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int MAX_WAIT = MAX_WAIT_DEF,
    localparam int WCNT_W   = $clog2(MAX_WAIT + 1),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              start,
    output logic [DATA_W-1:0] load_data,
    input  logic [DATA_W-1:0] cnt_data,
    input  logic [DATA_W-1:0] cnt_timer,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_timer,
    output logic [DATA_W-1:0] res_load,
    output logic              res_err,
    output state_t            dbg_state,
    output logic [CNT_W-1:0]  dbg_count
);

    state_t            state;
    state_t            state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              wait_done;
    logic              wait_expired;

    accum_job_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (start),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (dbg_count)
    );

    assign in_ready     = !fifo_full;
    assign wait_done    = (cnt_data == '0);
    assign wait_expired = (wcnt == WCNT_W'(MAX_WAIT));
    assign dbg_state    = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs; the LAUNCH pulse doubles as the FIFO pop.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        load_data = '0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                start     = 1'b1;
                load_data = fifo_head;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_done || wait_expired) state_nxt = REPORT;
            end
            REPORT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Watchdog counter and result capture; completion wins over timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt      <= '0;
            res_timer <= '0;
            res_load  <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                LAUNCH: begin
                    res_load <= fifo_head;
                    wcnt     <= '0;
                end
                WAIT: begin
                    if (wait_done) begin
                        res_timer <= cnt_timer;
                        res_err   <= 1'b0;
                    end else if (wait_expired) begin
                        res_timer <= cnt_timer;
                        res_err   <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_dispatch.sv
// Directed bench for accum_dispatch with a behavioural countdown unit attached.
module tb_accum_dispatch;
    import accum_pkg::*;

    localparam int W  = 7;  // {err, timer[2:0], load[2:0]}

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       start;
    logic [2:0] load_data;
    logic [2:0] cnt_data;
    logic [2:0] cnt_timer;
    logic       res_valid;
    logic       res_ready;
    logic [2:0] res_timer;
    logic [2:0] res_load;
    logic       res_err;
    state_t     dbg_state;
    logic [2:0] dbg_count;

    logic [2:0] m_data;
    logic [2:0] m_timer;
    logic       force_mode;

    logic [W-1:0] exp_q[$];
    int n_tests;
    int n_fail;

    accum_dispatch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .start     (start),
        .load_data (load_data),
        .cnt_data  (cnt_data),
        .cnt_timer (cnt_timer),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_timer (res_timer),
        .res_load  (res_load),
        .res_err   (res_err),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Countdown unit model: loads on start, then decrements data and counts timer up to zero.
    always @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_timer <= '0;
        end else if (start) begin
            m_data  <= load_data;
            m_timer <= '0;
        end else if (m_data != 0) begin
            m_data  <= m_data - 1'b1;
            m_timer <= m_timer + 1'b1;
        end
    end

    assign cnt_data  = force_mode ? 3'd4 : m_data;
    assign cnt_timer = force_mode ? 3'd5 : m_timer;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: offers one job for one edge and records the expected result if it should be taken.
    task automatic push_job(input logic [2:0] v, input logic acc, input logic [W-1:0] e);
        check("push_in_ready", in_ready, acc);
        if (acc) exp_q.push_back(e);
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
    endtask

    // Scoreboard: a result handshake will complete at the next edge.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("res_load", res_load, e[2:0]);
                check("res_timer", res_timer, e[5:3]);
                check("res_err", res_err, e[6]);
            end
        end
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        res_ready  = 1'b0;
        force_mode = 1'b0;

        // Reset for two cycles, then check output reset values.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_start", start, 0);
        check("rst_load_data", load_data, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_timer", res_timer, 0);
        check("rst_res_load", res_load, 0);
        check("rst_res_err", res_err, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_state", dbg_state, IDLE);
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_no_start", start, 0);
        end

        // Single job of load 3: start at t+2, result at t+7 with timer 3.
        push_job(3'd3, 1'b1, {1'b0, 3'd3, 3'd3});
        check("single_t1_start", start, 0);
        check("single_t1_state", dbg_state, IDLE);
        step();
        check("single_t2_start", start, 1);
        check("single_t2_load", load_data, 3);
        step();
        check("single_t3_state", dbg_state, WAIT);
        check("single_t3_start", start, 0);
        repeat (3) step();
        check("single_t6_valid", res_valid, 0);
        step();
        check("single_t7_valid", res_valid, 1);
        check("single_t7_load", res_load, 3);
        check("single_t7_err", res_err, 0);
        check("single_t7_timer", res_timer, 3);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("single_back_idle", dbg_state, IDLE);

        // FIFO fill with result stall; includes a push/pop in the same LAUNCH cycle.
        push_job(3'd5, 1'b1, {1'b0, 3'd5, 3'd5});
        push_job(3'd1, 1'b1, {1'b0, 3'd1, 3'd1});
        check("full_launch_start", start, 1);
        check("full_launch_load", load_data, 5);
        check("full_launch_count", dbg_count, 2);
        push_job(3'd0, 1'b1, {1'b0, 3'd0, 3'd0});
        check("pushpop_count", dbg_count, 2);
        check("pushpop_in_ready", in_ready, 1);
        push_job(3'd2, 1'b1, {1'b0, 3'd2, 3'd2});
        push_job(3'd6, 1'b1, {1'b0, 3'd6, 3'd6});
        check("full_count", dbg_count, 4);
        check("full_in_ready", in_ready, 0);
        push_job(3'd7, 1'b0, '0);
        check("refused_count", dbg_count, 4);
        repeat (10) step();
        check("stall_valid", res_valid, 1);
        check("stall_load", res_load, 5);
        check("stall_count", dbg_count, 4);
        res_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        check("drain_done", exp_q.size(), 0);
        step();
        res_ready = 1'b0;
        check("drain_idle", dbg_state, IDLE);
        check("drain_count", dbg_count, 0);

        // Timeout: data stuck at 4, timer shows 5; result after 16 WAIT cycles.
        force_mode = 1'b1;
        push_job(3'd2, 1'b1, {1'b1, 3'd5, 3'd2});
        step();
        check("to_start", start, 1);
        repeat (16) step();
        check("to_state_wait", dbg_state, WAIT);
        check("to_valid_early", res_valid, 0);
        step();
        check("to_valid", res_valid, 1);
        check("to_err", res_err, 1);
        check("to_timer", res_timer, 5);
        check("to_load", res_load, 2);
        res_ready = 1'b1;
        step();
        res_ready  = 1'b0;
        force_mode = 1'b0;
        check("to_done", exp_q.size(), 0);

        // Reset during WAIT with two jobs queued.
        push_job(3'd4, 1'b1, {1'b0, 3'd4, 3'd4});
        push_job(3'd3, 1'b1, {1'b0, 3'd3, 3'd3});
        push_job(3'd2, 1'b1, {1'b0, 3'd2, 3'd2});
        check("mid_state", dbg_state, WAIT);
        check("mid_count", dbg_count, 2);
        rst = 1'b1;
        step();
        exp_q.delete();
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_count", dbg_count, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_state", dbg_state, IDLE);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("mid_no_start", start, 0);
        end
        check("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
